mem_isq_ooo: RTL and testbench

MEM_ISQ_OOO -- requirements
Module: mem_isq_ooo

---
 rtl/mem_isq_ooo.sv | 122 ++++++++++++
 tb/tb_mem_isq_ooo.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_isq_ooo.sv
// Memory issue queue: age-ordered slot pool with writeback wakeup, flush by robid
// and either oldest-ready or strictly in-order issue selection.
module mem_isq_ooo #(
    parameter int DEPTH           = 8,
    parameter int DATA_WIDTH      = 248,
    parameter int CONDITION_WIDTH = 2,
    parameter int WB_PORTS        = 2,
    parameter int ISSUE_MODE      = 1,
    parameter int ROB_SIZE_LOG    = 6,
    localparam int RW             = ROB_SIZE_LOG + 1,
    localparam int IW             = $clog2(DEPTH)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                enqueue_valid,
    output logic                                enqueue_ready,
    input  logic [DATA_WIDTH-1:0]               enqueue_data,
    input  logic [CONDITION_WIDTH-1:0]          enqueue_condition,
    input  logic [RW-1:0]                       enqueue_robid,
    output logic                                dequeue_valid,
    input  logic                                dequeue_ready,
    output logic [DATA_WIDTH-1:0]               dequeue_data,
    output logic [CONDITION_WIDTH-1:0]          dequeue_condition,
    output logic [RW-1:0]                       dequeue_robid,
    output logic [IW-1:0]                       dequeue_selfid,
    output logic [IW:0]                         entry_count,
    input  logic                                flush_valid,
    input  logic [RW-1:0]                       flush_robid,
    input  logic [WB_PORTS-1:0]                 wb_valid,
    input  logic [WB_PORTS*RW-1:0]              wb_robid,
    input  logic [WB_PORTS*CONDITION_WIDTH-1:0] wb_data
);

    logic [DEPTH-1:0]           valid_q, valid_d, keep, ready_vec;
    logic [DATA_WIDTH-1:0]      data_q  [DEPTH];
    logic [CONDITION_WIDTH-1:0] cond_q  [DEPTH];
    logic [RW-1:0]              robid_q [DEPTH];
    logic [CONDITION_WIDTH-1:0] wake_slot [DEPTH];
    logic [CONDITION_WIDTH-1:0] wake_enq;
    logic [IW-1:0]              sel_idx, free_idx;
    logic                       sel_found, free_found, issue_ok, enq_fire, deq_fire;
    logic [IW:0]                count_d;

    // Wrap bit flips each ROB lap, so a differing wrap inverts the index compare.
    function automatic logic is_older(input logic [RW-1:0] a, input logic [RW-1:0] b);
        if (a[RW-1] == b[RW-1]) return a[RW-2:0] < b[RW-2:0];
        else                    return a[RW-2:0] > b[RW-2:0];
    endfunction

    assign enqueue_ready = (entry_count != (IW+1)'(DEPTH));

    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        wake_enq   = '0;
        count_d    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = valid_q[i] && (&cond_q[i]);
            if (((ISSUE_MODE != 0) ? ready_vec[i] : valid_q[i]) &&
                (!sel_found || is_older(robid_q[i], robid_q[sel_idx]))) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end

        issue_ok = sel_found && ready_vec[sel_idx] && !flush_valid;
        deq_fire = issue_ok && dequeue_ready;
        enq_fire = enqueue_valid && enqueue_ready && free_found &&
                   !(flush_valid && is_older(flush_robid, enqueue_robid));

        for (int k = 0; k < WB_PORTS; k++)
            if (wb_valid[k] && wb_robid[k*RW +: RW] == enqueue_robid)
                wake_enq = wake_enq | wb_data[k*CONDITION_WIDTH +: CONDITION_WIDTH];

        for (int i = 0; i < DEPTH; i++) begin
            wake_slot[i] = '0;
            for (int k = 0; k < WB_PORTS; k++)
                if (wb_valid[k] && wb_robid[k*RW +: RW] == robid_q[i])
                    wake_slot[i] = wake_slot[i] | wb_data[k*CONDITION_WIDTH +: CONDITION_WIDTH];
            keep[i]    = valid_q[i] && !(deq_fire && sel_idx == IW'(i)) &&
                         !(flush_valid && is_older(flush_robid, robid_q[i]));
            valid_d[i] = keep[i] || (enq_fire && free_idx == IW'(i));
            count_d    = count_d + (IW+1)'(valid_d[i]);
        end
    end

    assign dequeue_valid     = issue_ok;
    assign dequeue_data      = data_q[sel_idx];
    assign dequeue_condition = cond_q[sel_idx];
    assign dequeue_robid     = robid_q[sel_idx];
    assign dequeue_selfid    = sel_idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q     <= '0;
            entry_count <= '0;
        end else begin
            valid_q     <= valid_d;
            entry_count <= count_d;
        end
    end

    // Payload storage is not reset; valid_q alone defines occupancy.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (enq_fire && free_idx == IW'(i)) begin
                data_q[i]  <= enqueue_data;
                cond_q[i]  <= enqueue_condition | wake_enq;
                robid_q[i] <= enqueue_robid;
            end else if (keep[i]) begin
                cond_q[i]  <= cond_q[i] | wake_slot[i];
            end
        end
    end

endmodule

// File: tb/tb_mem_isq_ooo.sv
// Directed bench for mem_isq_ooo: one oldest-ready instance and one in-order
// instance share stimulus except for their dequeue_ready inputs.
module tb_mem_isq_ooo;

    logic         clock = 1'b0;
    logic         reset;
    logic         enqueue_valid;
    logic [247:0] enqueue_data;
    logic [1:0]   enqueue_condition;
    logic [6:0]   enqueue_robid;
    logic         deq_rdy1, deq_rdy0;
    logic         flush_valid;
    logic [6:0]   flush_robid;
    logic [1:0]   wb_valid;
    logic [13:0]  wb_robid;
    logic [3:0]   wb_data;

    logic         enq_rdy1, deq_vld1, enq_rdy0, deq_vld0;
    logic [247:0] deq_data1, deq_data0;
    logic [1:0]   deq_cond1, deq_cond0;
    logic [6:0]   deq_robid1, deq_robid0;
    logic [2:0]   deq_self1, deq_self0;
    logic [3:0]   count1, count0;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    mem_isq_ooo #(.ISSUE_MODE(1)) dut1 (
        .clock(clock), .reset(reset),
        .enqueue_valid(enqueue_valid), .enqueue_ready(enq_rdy1),
        .enqueue_data(enqueue_data), .enqueue_condition(enqueue_condition),
        .enqueue_robid(enqueue_robid),
        .dequeue_valid(deq_vld1), .dequeue_ready(deq_rdy1),
        .dequeue_data(deq_data1), .dequeue_condition(deq_cond1),
        .dequeue_robid(deq_robid1), .dequeue_selfid(deq_self1),
        .entry_count(count1),
        .flush_valid(flush_valid), .flush_robid(flush_robid),
        .wb_valid(wb_valid), .wb_robid(wb_robid), .wb_data(wb_data));

    mem_isq_ooo #(.ISSUE_MODE(0)) dut0 (
        .clock(clock), .reset(reset),
        .enqueue_valid(enqueue_valid), .enqueue_ready(enq_rdy0),
        .enqueue_data(enqueue_data), .enqueue_condition(enqueue_condition),
        .enqueue_robid(enqueue_robid),
        .dequeue_valid(deq_vld0), .dequeue_ready(deq_rdy0),
        .dequeue_data(deq_data0), .dequeue_condition(deq_cond0),
        .dequeue_robid(deq_robid0), .dequeue_selfid(deq_self0),
        .entry_count(count0),
        .flush_valid(flush_valid), .flush_robid(flush_robid),
        .wb_valid(wb_valid), .wb_robid(wb_robid), .wb_data(wb_data));

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [247:0] pay(input logic [6:0] r);
        return {31{{1'b0, r}}};
    endfunction

    task automatic enq(input logic [6:0] r, input logic [1:0] c);
        enqueue_valid     = 1'b1;
        enqueue_robid     = r;
        enqueue_condition = c;
        enqueue_data      = pay(r);
        step();
        enqueue_valid     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enqueue_valid = 0; enqueue_data = '0; enqueue_condition = '0;
        enqueue_robid = '0; deq_rdy1 = 0; deq_rdy0 = 0; flush_valid = 0;
        flush_robid = '0; wb_valid = '0; wb_robid = '0; wb_data = '0;
        step(); step();
        reset = 1'b0;
        check("rst_count", count1, 0);
        check("rst_enq_ready", enq_rdy1, 1);
        check("rst_deq_valid", deq_vld1, 0);

        // fill to full, then drain in robid order
        for (int r = 0; r < 8; r++) enq(7'(r), 2'b11);
        check("fill_count", count1, 8);
        check("fill_enq_ready", enq_rdy1, 0);
        check("fill_first_robid", deq_robid1, 0);
        check("fill_first_data", deq_data1, pay(7'd0));
        enqueue_valid = 1'b1; enqueue_robid = 7'd9; enqueue_condition = 2'b11;
        deq_rdy1 = 1'b1;
        #1;
        check("full_enq_blocked", enq_rdy1, 0);
        step();
        enqueue_valid = 1'b0;
        check("full_deq_count", count1, 7);
        for (int r = 1; r < 8; r++) begin
            check("drain_valid", deq_vld1, 1);
            check("drain_robid", deq_robid1, 256'(r));
            check("drain_selfid", deq_self1, 256'(r));
            check("drain_data", deq_data1, pay(7'(r)));
            step();
        end
        check("drain_count", count1, 0);
        check("drain_empty", deq_vld1, 0);
        deq_rdy1 = 1'b0;

        // wakeup: oldest-ready vs in-order
        do_reset();
        enq(7'd3, 2'b00);
        enq(7'd5, 2'b11);
        check("wk_m1_valid", deq_vld1, 1);
        check("wk_m1_robid", deq_robid1, 5);
        check("wk_m0_blocked", deq_vld0, 0);
        deq_rdy1 = 1'b1;
        step();
        deq_rdy1 = 1'b0;
        check("wk_m1_after5", deq_vld1, 0);
        check("wk_m1_count", count1, 1);
        wb_valid = 2'b10; wb_robid = {7'd3, 7'd0}; wb_data = 4'b1100;
        #1;
        check("wk_m0_same_cycle", deq_vld0, 0);
        step();
        wb_valid = '0;
        check("wk_m1_robid3", deq_robid1, 3);
        check("wk_m1_valid3", deq_vld1, 1);
        check("wk_m0_valid3", deq_vld0, 1);
        check("wk_m0_robid3", deq_robid0, 3);
        check("wk_m0_cond3", deq_cond0, 2'b11);
        deq_rdy1 = 1'b1; deq_rdy0 = 1'b1;
        step();
        deq_rdy1 = 1'b0;
        check("wk_m1_empty", count1, 0);
        check("wk_m0_then5", deq_robid0, 5);
        check("wk_m0_valid5", deq_vld0, 1);
        step();
        deq_rdy0 = 1'b0;
        check("wk_m0_empty", count0, 0);

        // writeback hitting a same-cycle enqueue
        wb_valid = 2'b01; wb_robid = {7'd0, 7'd8}; wb_data = 4'b0010;
        enq(7'd8, 2'b01);
        wb_valid = '0;
        check("enq_wb_valid", deq_vld1, 1);
        check("enq_wb_cond", deq_cond1, 2'b11);

        // flush: younger than 4 removed, same-cycle younger enqueue dropped
        do_reset();
        enq(7'd2, 2'b11); enq(7'd4, 2'b11); enq(7'd6, 2'b11);
        flush_valid = 1'b1; flush_robid = 7'd4;
        enqueue_valid = 1'b1; enqueue_robid = 7'd7; enqueue_condition = 2'b11;
        deq_rdy1 = 1'b1;
        #1;
        check("fl_deq_blocked", deq_vld1, 0);
        step();
        check("fl_count", count1, 2);
        enqueue_robid = 7'd4;
        #1;
        check("fl2_deq_blocked", deq_vld1, 0);
        step();
        flush_valid = 1'b0; enqueue_valid = 1'b0;
        check("fl_equal_kept", count1, 3);
        check("fl_robid_a", deq_robid1, 2);
        step();
        check("fl_robid_b", deq_robid1, 4);
        check("fl_selfid_b", deq_self1, 1);
        step();
        check("fl_robid_c", deq_robid1, 4);
        check("fl_selfid_c", deq_self1, 2);
        step();
        check("fl_drained", count1, 0);
        deq_rdy1 = 1'b0;

        // wrap-bit age compare
        do_reset();
        enq(7'h41, 2'b11);
        enq(7'h3E, 2'b11);
        check("wr_oldest", deq_robid1, 7'h3E);
        check("wr_selfid", deq_self1, 1);
        flush_valid = 1'b1; flush_robid = 7'h3F;
        step();
        flush_valid = 1'b0;
        check("wr_count", count1, 1);
        check("wr_kept", deq_robid1, 7'h3E);

        // reset during activity
        do_reset();
        for (int r = 10; r < 15; r++) enq(7'(r), 2'b00);
        check("mr_pre_count", count1, 5);
        reset = 1'b1;
        enqueue_valid = 1'b1; enqueue_robid = 7'd15; enqueue_condition = 2'b11;
        wb_valid = 2'b01; wb_robid = {7'd0, 7'd10}; wb_data = 4'b0011;
        deq_rdy1 = 1'b1;
        step();
        reset = 1'b0; enqueue_valid = 1'b0; wb_valid = '0;
        check("mr_count", count1, 0);
        check("mr_deq_valid", deq_vld1, 0);
        check("mr_enq_ready", enq_rdy1, 1);
        step();
        check("mr_stays_empty", count1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
